// File: rtl/mcu_pkg.sv
// mcu_pkg: state, ALU, mux-select and opcode encodings shared by the multicycle controller.
package mcu_pkg;

    // JALR2 has the same outputs and successor as JAL, so both share S_JAL.
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JAL    = 4'd10,
        S_JALR1  = 4'd11,
        S_LUI    = 4'd12,
        S_AUIPC  = 4'd13,
        S_TRAP   = 4'd14
    } state_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_e;

    typedef enum logic [1:0] {CLS_ADD, CLS_SUB, CLS_R, CLS_I} alu_cls_e;

    localparam logic [1:0] SRCA_PC = 2'd0, SRCA_OLDPC = 2'd1, SRCA_RS1 = 2'd2, SRCA_ZERO = 2'd3;
    localparam logic [1:0] SRCB_RS2 = 2'd0, SRCB_IMM = 2'd1, SRCB_FOUR = 2'd2;
    localparam logic [1:0] RES_ALUOUT = 2'd0, RES_RDATA = 2'd1, RES_ALU = 2'd2;
    localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3, IMM_U = 3'd4;

    localparam logic [6:0] OP_LOAD = 7'h03, OP_STORE = 7'h23, OP_R = 7'h33, OP_I = 7'h13;
    localparam logic [6:0] OP_BRANCH = 7'h63, OP_JAL = 7'h6F, OP_JALR = 7'h67;
    localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17;

    function automatic logic [2:0] imm_sel(input logic [6:0] op);
        return op == OP_STORE  ? IMM_S :
               op == OP_BRANCH ? IMM_B :
               op == OP_JAL    ? IMM_J :
               (op == OP_LUI || op == OP_AUIPC) ? IMM_U : IMM_I;
    endfunction

endpackage

// File: rtl/mcu_alu_decoder.sv
// mcu_alu_decoder: maps the state's ALU class plus func3/func7_5 to an ALU operation code.
module mcu_alu_decoder
    import mcu_pkg::*;
(
    input  logic [1:0] cls,
    input  logic [2:0] func3,
    input  logic       func7_5,
    output logic [3:0] alu_ctl
);

    logic is_r;

    assign is_r = cls == CLS_R;

    always_comb begin
        alu_ctl = ALU_ADD;
        if (cls == CLS_SUB)
            alu_ctl = ALU_SUB;
        else if (cls == CLS_R || cls == CLS_I)
            case (func3)
                3'b000:  alu_ctl = (is_r && func7_5) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_ctl = ALU_SLL;
                3'b010:  alu_ctl = ALU_SLT;
                3'b011:  alu_ctl = ALU_SLTU;
                3'b100:  alu_ctl = ALU_XOR;
                3'b101:  alu_ctl = func7_5 ? ALU_SRA : ALU_SRL;
                3'b110:  alu_ctl = ALU_OR;
                default: alu_ctl = ALU_AND;
            endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: Moore FSM sequencing the multicycle RV32I datapath.
// Performance counters are built only when MCU_PERF_CNT_EN is defined.
module multicycle_control_unit
    import mcu_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       func3,
    input  logic             func7_5,
    input  logic             zero,
    input  logic             neg,
    input  logic             carry,
    input  logic             ovf,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             adr_src,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       imm_src,
    output logic [3:0]       alu_ctl,
    output logic             illegal,
    output logic             bus_err,
    output logic [3:0]       state_dbg,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    state_e     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic       bus_err_q, bus_err_d;
    logic [1:0] alu_cls;
    logic       waiting, timeout_hit, taken;

    mcu_alu_decoder u_alu_dec (
        .cls     (alu_cls),
        .func3   (func3),
        .func7_5 (func7_5),
        .alu_ctl (alu_ctl)
    );

    assign imm_src     = imm_sel(opcode);
    assign state_dbg   = state_q;
    assign bus_err     = bus_err_q && state_q == S_TRAP;
    assign waiting     = (state_q == S_FETCH || state_q == S_MEMRD || state_q == S_MEMWR) && !mem_ready;
    assign timeout_hit = TIMEOUT != 0 && waiting && int'(timer_q) + 1 == TIMEOUT;
    assign taken       = func3 == 3'b000 ? zero :
                         func3 == 3'b001 ? !zero :
                         func3 == 3'b100 ? neg ^ ovf :
                         func3 == 3'b101 ? !(neg ^ ovf) :
                         func3 == 3'b110 ? !carry : carry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            timer_q   <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_cls    = CLS_ADD;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                state_d    = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                state_d   = (opcode == OP_LOAD || opcode == OP_STORE) ? S_MEMADR :
                            opcode == OP_R      ? S_EXECR  :
                            opcode == OP_I      ? S_EXECI  :
                            opcode == OP_BRANCH ? S_BRANCH :
                            opcode == OP_JAL    ? S_JAL    :
                            (opcode == OP_JALR && func3 == 3'b000) ? S_JALR1 :
                            opcode == OP_LUI    ? S_LUI    :
                            opcode == OP_AUIPC  ? S_AUIPC  : S_TRAP;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                state_d   = opcode == OP_LOAD ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                adr_src  = 1'b1;
                mem_read = 1'b1;
                state_d  = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                result_src = RES_RDATA;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                state_d   = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXECR, S_EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = state_q == S_EXECI ? SRCB_IMM : SRCB_RS2;
                alu_cls   = state_q == S_EXECI ? CLS_I : CLS_R;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = SRCA_RS1;
                alu_cls   = CLS_SUB;
                // func3 010/011 are not branches in RV32I.
                pc_write  = taken && func3[2:1] != 2'b01;
                state_d   = func3[2:1] == 2'b01 ? S_TRAP : S_FETCH;
            end
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_write  = 1'b1;
                state_d   = S_ALUWB;
            end
            S_JALR1: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                state_d   = S_JAL;
            end
            S_LUI, S_AUIPC: begin
                alu_src_a = state_q == S_LUI ? SRCA_ZERO : SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                state_d   = S_ALUWB;
            end
            default: illegal = 1'b1;
        endcase
        if (timeout_hit)
            state_d = S_TRAP;
        if (rst) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            mem_write = 1'b0;
        end
        timer_d   = (waiting && state_d == state_q) ? timer_q + 8'd1 : 8'd0;
        bus_err_d = bus_err_q || timeout_hit;
    end

`ifdef MCU_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_q, instret_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            if (state_q != S_TRAP)
                cycle_q <= cycle_q + 1'b1;
            if (state_d == S_FETCH && state_q != S_FETCH)
                instret_q <= instret_q + 1'b1;
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: vector table of single instructions plus hand-written multi-cycle sequences.
module tb_multicycle_control_unit;

    logic       clk = 1'b0, rst = 1'b0;
    logic [6:0] opcode = 7'h13;
    logic [2:0] func3 = 3'b000;
    logic       func7_5 = 1'b0, zero = 1'b0, neg = 1'b0, carry = 1'b0, ovf = 1'b0, mem_ready = 1'b1;
    logic       pc_write, adr_src, mem_read, mem_write, ir_write, reg_write, illegal, bus_err;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] imm_src;
    logic [3:0] alu_ctl, state_dbg;
    logic [3:0] cycle_cnt, instret_cnt;

    int errors = 0, checks = 0;

    multicycle_control_unit #(.CNT_W(4), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7_5(func7_5),
        .zero(zero), .neg(neg), .carry(carry), .ovf(ovf), .mem_ready(mem_ready),
        .pc_write(pc_write), .adr_src(adr_src), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src), .alu_ctl(alu_ctl),
        .illegal(illegal), .bus_err(bus_err), .state_dbg(state_dbg),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic [3:0] flg;
        logic [3:0] s2;
        logic [3:0] alu;
        logic [2:0] imm;
        logic       pcw;
        logic [3:0] s3;
    } vec_t;

    vec_t v [25];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // {op, f3, f7, {z,n,c,v}, state after DECODE, alu_ctl there, imm_src, pc_write there, next state}
        v = '{
            '{7'h13, 3'b000, 1'b0, 4'b0000, 4'd7,  4'd0, 3'd0, 1'b0, 4'd8},
            '{7'h13, 3'b000, 1'b1, 4'b0000, 4'd7,  4'd0, 3'd0, 1'b0, 4'd8},
            '{7'h13, 3'b101, 1'b1, 4'b0000, 4'd7,  4'd9, 3'd0, 1'b0, 4'd8},
            '{7'h13, 3'b101, 1'b0, 4'b0000, 4'd7,  4'd8, 3'd0, 1'b0, 4'd8},
            '{7'h13, 3'b100, 1'b0, 4'b0000, 4'd7,  4'd4, 3'd0, 1'b0, 4'd8},
            '{7'h33, 3'b000, 1'b1, 4'b0000, 4'd6,  4'd1, 3'd0, 1'b0, 4'd8},
            '{7'h33, 3'b001, 1'b0, 4'b0000, 4'd6,  4'd7, 3'd0, 1'b0, 4'd8},
            '{7'h33, 3'b011, 1'b0, 4'b0000, 4'd6,  4'd6, 3'd0, 1'b0, 4'd8},
            '{7'h33, 3'b111, 1'b0, 4'b0000, 4'd6,  4'd2, 3'd0, 1'b0, 4'd8},
            '{7'h63, 3'b110, 1'b0, 4'b0000, 4'd9,  4'd1, 3'd2, 1'b1, 4'd0},
            '{7'h63, 3'b101, 1'b0, 4'b0100, 4'd9,  4'd1, 3'd2, 1'b0, 4'd0},
            '{7'h63, 3'b000, 1'b0, 4'b1000, 4'd9,  4'd1, 3'd2, 1'b1, 4'd0},
            '{7'h63, 3'b001, 1'b0, 4'b1000, 4'd9,  4'd1, 3'd2, 1'b0, 4'd0},
            '{7'h63, 3'b111, 1'b0, 4'b0010, 4'd9,  4'd1, 3'd2, 1'b1, 4'd0},
            '{7'h63, 3'b100, 1'b0, 4'b0101, 4'd9,  4'd1, 3'd2, 1'b0, 4'd0},
            '{7'h63, 3'b100, 1'b0, 4'b0001, 4'd9,  4'd1, 3'd2, 1'b1, 4'd0},
            '{7'h63, 3'b010, 1'b0, 4'b1111, 4'd9,  4'd1, 3'd2, 1'b0, 4'd14},
            '{7'h6F, 3'b000, 1'b0, 4'b0000, 4'd10, 4'd0, 3'd3, 1'b1, 4'd8},
            '{7'h67, 3'b000, 1'b0, 4'b0000, 4'd11, 4'd0, 3'd0, 1'b0, 4'd10},
            '{7'h37, 3'b000, 1'b0, 4'b0000, 4'd12, 4'd0, 3'd4, 1'b0, 4'd8},
            '{7'h17, 3'b000, 1'b0, 4'b0000, 4'd13, 4'd0, 3'd4, 1'b0, 4'd8},
            '{7'h7F, 3'b000, 1'b0, 4'b0000, 4'd14, 4'd0, 3'd0, 1'b0, 4'd14},
            '{7'h67, 3'b001, 1'b0, 4'b0000, 4'd14, 4'd0, 3'd0, 1'b0, 4'd14},
            '{7'h23, 3'b010, 1'b0, 4'b0000, 4'd2,  4'd0, 3'd1, 1'b0, 4'd5},
            '{7'h03, 3'b010, 1'b0, 4'b0000, 4'd2,  4'd0, 3'd0, 1'b0, 4'd3}
        };

        // Reset state, with mem_ready high so the enable gating during rst is visible.
        #2 rst = 1'b1;
        #1;
        chk("rst_state", 32'(state_dbg), 0);
        chk("rst_enables", {pc_write, ir_write, reg_write, mem_write, mem_read}, 5'b00001);
        chk("rst_counters", {cycle_cnt, instret_cnt}, 0);
        do_reset();

        foreach (v[i]) begin
            do_reset();
            opcode = v[i].op; func3 = v[i].f3; func7_5 = v[i].f7;
            {zero, neg, carry, ovf} = v[i].flg;
            mem_ready = 1'b1;
            #1;
            chk($sformatf("v%0d_fetch", i), {state_dbg, ir_write, pc_write, alu_src_b, result_src}, {4'd0, 1'b1, 1'b1, 2'd2, 2'd2});
            tick();
            chk($sformatf("v%0d_decode", i), {state_dbg, imm_src, alu_src_a, alu_src_b, pc_write}, {4'd1, v[i].imm, 2'd1, 2'd1, 1'b0});
            tick();
            chk($sformatf("v%0d_s2", i), 32'(state_dbg), 32'(v[i].s2));
            chk($sformatf("v%0d_alu", i), 32'(alu_ctl), 32'(v[i].alu));
            chk($sformatf("v%0d_pcw", i), 32'(pc_write), 32'(v[i].pcw));
            tick();
            chk($sformatf("v%0d_s3", i), 32'(state_dbg), 32'(v[i].s3));
        end

        // ADDI walks FETCH, DECODE, EXECI, ALUWB and writes the register file once.
        do_reset();
        opcode = 7'h13; func3 = 3'b000; func7_5 = 1'b0; mem_ready = 1'b1;
        #1;
        n = 0;
        for (int c = 0; c < 4; c++) begin
            logic [3:0] path [4];
            path = '{4'd0, 4'd1, 4'd7, 4'd8};
            chk($sformatf("addi_path%0d", c), 32'(state_dbg), 32'(path[c]));
            n += int'(reg_write);
            tick();
        end
        chk("addi_regwr_once", n, 1);
        chk("addi_back_fetch", 32'(state_dbg), 0);

        // LW with three wait states in MEMRD.
        do_reset();
        opcode = 7'h03; func3 = 3'b010; mem_ready = 1'b1;
        #1;
        tick();
        tick();
        chk("lw_memadr", {state_dbg, alu_src_a, alu_src_b}, {4'd2, 2'd2, 2'd1});
        mem_ready = 1'b0;
        tick();
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("lw_wait%0d", c), {state_dbg, mem_read, adr_src}, {4'd3, 1'b1, 1'b1});
            tick();
        end
        mem_ready = 1'b1;
        #1;
        chk("lw_ready", {state_dbg, mem_read, adr_src}, {4'd3, 1'b1, 1'b1});
        tick();
        chk("lw_memwb", {state_dbg, result_src, reg_write, mem_read}, {4'd4, 2'd1, 1'b1, 1'b0});
        tick();
        chk("lw_done", 32'(state_dbg), 0);

        // Illegal opcode: TRAP is sticky with every enable low.
        do_reset();
        opcode = 7'h7F; mem_ready = 1'b1;
        #1;
        tick();
        tick();
        for (int c = 0; c < 20; c++) begin
            chk($sformatf("trap_hold%0d", c), {state_dbg, illegal, bus_err, pc_write, ir_write, reg_write, mem_write, mem_read},
                {4'd14, 1'b1, 1'b0, 5'b00000});
            tick();
        end
        do_reset();
        chk("trap_recover", {state_dbg, illegal, mem_read}, {4'd0, 1'b0, 1'b1});

        // Fetch timeout after four wait cycles.
        opcode = 7'h13;
        mem_ready = 1'b0;
        #1;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("to_wait%0d", c), {state_dbg, mem_read, illegal}, {4'd0, 1'b1, 1'b0});
            tick();
        end
        chk("to_trap", {state_dbg, illegal, bus_err, mem_read}, {4'd14, 1'b1, 1'b1, 1'b0});
        mem_ready = 1'b1;
        tick();
        chk("to_sticky", {state_dbg, bus_err}, {4'd14, 1'b1});

        // Asynchronous reset in the middle of a store wait.
        do_reset();
        chk("post_to_reset", {state_dbg, bus_err}, {4'd0, 1'b0});
        opcode = 7'h23; func3 = 3'b010; mem_ready = 1'b1;
        #1;
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        chk("sw_memwr", {state_dbg, mem_write, adr_src}, {4'd5, 1'b1, 1'b1});
        #1 rst = 1'b1;
        #1;
        chk("sw_async_rst", {state_dbg, mem_write, mem_read}, {4'd0, 1'b0, 1'b1});

        // Five back-to-back ADDIs: 20 cycles wraps a 4-bit cycle counter to 4.
        do_reset();
        opcode = 7'h13; func3 = 3'b000; mem_ready = 1'b1;
        #1;
        repeat (20) tick();
        chk("perf_state", 32'(state_dbg), 0);
`ifdef MCU_PERF_CNT_EN
        chk("perf_instret", 32'(instret_cnt), 5);
        chk("perf_cycle", 32'(cycle_cnt), 4);
`else
        chk("perf_instret", 32'(instret_cnt), 0);
        chk("perf_cycle", 32'(cycle_cnt), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
